sha256_digest_accumulator: RTL

- Consumer end of the SHA-256 compression datapath.
- Receives the eight final working variables a..h of each compressed 512-bit block as a word stream and performs the feed-forward update H[i] = H[i] + word (mod 2^32) through one instance of the shared 32-bit adder.
- After the last message block, streams the 256-bit digest out as eight 32-bit words over a valid/ready interface.
- Then re-arms itself with the SHA-256 initial hash values.

---
 rtl/sha256_pkg.sv | 37 +++
 rtl/sha256_digest_accumulator_if.sv | 25 ++
 rtl/sha256_digest_accumulator_adder.sv | 15 +
 rtl/sha256_digest_accumulator.sv | 102 ++++++++++
 4 files changed

// File: rtl/sha256_pkg.sv
// Shared SHA-256 constants: word geometry, initial hash values, state encoding.
package sha256_pkg;

  localparam int unsigned DATA_W    = 32;
  localparam int unsigned NUM_WORDS = 8;
  localparam int unsigned IDX_W     = 3;

  localparam logic [DATA_W-1:0] H0_INIT = 32'h6a09e667;
  localparam logic [DATA_W-1:0] H1_INIT = 32'hbb67ae85;
  localparam logic [DATA_W-1:0] H2_INIT = 32'h3c6ef372;
  localparam logic [DATA_W-1:0] H3_INIT = 32'ha54ff53a;
  localparam logic [DATA_W-1:0] H4_INIT = 32'h510e527f;
  localparam logic [DATA_W-1:0] H5_INIT = 32'h9b05688c;
  localparam logic [DATA_W-1:0] H6_INIT = 32'h1f83d9ab;
  localparam logic [DATA_W-1:0] H7_INIT = 32'h5be0cd19;

  localparam logic [1:0] StIdle  = 2'd0;
  localparam logic [1:0] StAccum = 2'd1;
  localparam logic [1:0] StDrain = 2'd2;

  // Initial hash value for word index i.
  function automatic logic [DATA_W-1:0] iv_word(input logic [IDX_W-1:0] i);
    logic [DATA_W-1:0] v;
    unique case (i)
      3'd0:    v = H0_INIT;
      3'd1:    v = H1_INIT;
      3'd2:    v = H2_INIT;
      3'd3:    v = H3_INIT;
      3'd4:    v = H4_INIT;
      3'd5:    v = H5_INIT;
      3'd6:    v = H6_INIT;
      default: v = H7_INIT;
    endcase
    return v;
  endfunction

endpackage

// File: rtl/sha256_digest_accumulator_if.sv
// Feed-forward word stream in, digest word stream out.
interface sha256_digest_accumulator_if;
  import sha256_pkg::*;

  logic              ff_valid_i;
  logic              ff_ready_o;
  logic [DATA_W-1:0] ff_word_i;
  logic              ff_last_i;
  logic              dout_valid_o;
  logic              dout_ready_i;
  logic [DATA_W-1:0] dout_data_o;
  logic              dout_last_o;

  // Producer of working variables and consumer of the digest.
  modport master (
    output ff_valid_i, ff_word_i, ff_last_i, dout_ready_i,
    input  ff_ready_o, dout_valid_o, dout_data_o, dout_last_o
  );

  // The accumulator itself.
  modport slave (
    input  ff_valid_i, ff_word_i, ff_last_i, dout_ready_i,
    output ff_ready_o, dout_valid_o, dout_data_o, dout_last_o
  );
endinterface

// File: rtl/sha256_digest_accumulator_adder.sv
// Shared 32-bit adder; carry-out is not needed by any SHA-256 user, sum wraps mod 2^32.
module adder_32bit
  import sha256_pkg::*;
(
  input  logic [DATA_W-1:0] a_i,
  input  logic [DATA_W-1:0] b_i,
  output logic [DATA_W-1:0] sum_o
);

  // Plain modular sum.
  always_comb begin
    sum_o = a_i + b_i;
  end

endmodule

// File: rtl/sha256_digest_accumulator.sv
// SHA-256 feed-forward accumulator: H[i] += working variable, then streams the digest.
module sha256_digest_accumulator
  import sha256_pkg::*;
(
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          init_i,
  output logic                          busy_o,
  sha256_digest_accumulator_if.slave    bus_if
);

  logic [1:0]        state_q, state_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [DATA_W-1:0] h_q [NUM_WORDS];
  logic [DATA_W-1:0] h_d [NUM_WORDS];
  logic [DATA_W-1:0] sum;
  logic              ff_fire;
  logic              dout_fire;
  logic              last_idx;

  adder_32bit u_adder (
    .a_i   (h_q[idx_q]),
    .b_i   (bus_if.ff_word_i),
    .sum_o (sum)
  );

  // Outputs decode directly from registered state, so drain data is stable while stalled.
  always_comb begin
    bus_if.ff_ready_o   = (state_q != StDrain) && !rst && !init_i;
    bus_if.dout_valid_o = (state_q == StDrain);
    bus_if.dout_data_o  = (state_q == StDrain) ? h_q[idx_q] : '0;
    bus_if.dout_last_o  = (state_q == StDrain) && last_idx;
    busy_o              = (state_q != StIdle);
  end

  assign last_idx  = (idx_q == IDX_W'(NUM_WORDS - 1));
  assign ff_fire   = bus_if.ff_valid_i && bus_if.ff_ready_o;
  assign dout_fire = bus_if.dout_valid_o && bus_if.dout_ready_i;

  // Next-state: accumulate, chain or drain; init_i overrides any concurrent transfer.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    h_d     = h_q;
    if (init_i) begin
      for (int i = 0; i < NUM_WORDS; i++) h_d[i] = iv_word(IDX_W'(i));
      idx_d   = '0;
      state_d = StIdle;
    end else begin
      case (state_q)
        StIdle: begin
          if (ff_fire) begin
            h_d[idx_q] = sum;
            idx_d      = idx_q + IDX_W'(1);
            state_d    = StAccum;
          end
        end
        StAccum: begin
          if (ff_fire) begin
            h_d[idx_q] = sum;
            if (last_idx) begin
              idx_d   = '0;
              // Non-final blocks leave H in place as the chaining value.
              state_d = bus_if.ff_last_i ? StDrain : StIdle;
            end else begin
              idx_d = idx_q + IDX_W'(1);
            end
          end
        end
        StDrain: begin
          if (dout_fire) begin
            if (last_idx) begin
              for (int i = 0; i < NUM_WORDS; i++) h_d[i] = iv_word(IDX_W'(i));
              idx_d   = '0;
              state_d = StIdle;
            end else begin
              idx_d = idx_q + IDX_W'(1);
            end
          end
        end
        default: begin
          idx_d   = '0;
          state_d = StIdle;
        end
      endcase
    end
  end

  // State registers with synchronous reset to IV.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_WORDS; i++) h_q[i] <= iv_word(IDX_W'(i));
      idx_q   <= '0;
      state_q <= StIdle;
    end else begin
      h_q     <= h_d;
      idx_q   <= idx_d;
      state_q <= state_d;
    end
  end

endmodule
